// File: rtl/arch_regfile_dump_ctrl_if.sv
// Bus bundle for the architectural regfile dump engine: the regfile read channel
// and the dump record stream. The engine is the master on both.
interface arch_regfile_dump_ctrl_if #(
   parameter int unsigned ARCH_REG_ADDR_W = 5,
   parameter int unsigned REG_VAL_W       = 32
);

   logic                       rd_en;
   logic [ARCH_REG_ADDR_W-1:0] read_red_addr_req;
   logic [REG_VAL_W-1:0]       read_value;
   logic                       read_valid;

   logic                       out_valid;
   logic                       out_ready;
   logic [ARCH_REG_ADDR_W-1:0] out_addr;
   logic [REG_VAL_W-1:0]       out_value;

   modport master (
      output rd_en,
      output read_red_addr_req,
      input  read_value,
      input  read_valid,
      output out_valid,
      input  out_ready,
      output out_addr,
      output out_value
   );

   modport slave (
      input  rd_en,
      input  read_red_addr_req,
      output read_value,
      output read_valid,
      input  out_valid,
      output out_ready,
      input  out_addr,
      input  out_value
   );

endinterface

// File: rtl/arch_regfile_dump_ctrl.sv
// Architectural register file dump engine: walks registers 0..NUM_ARCH_REGS-1, one
// outstanding read at a time, and streams (address, value) records out.
module arch_regfile_dump_ctrl #(
   parameter int unsigned NUM_ARCH_REGS   = 32,
   parameter int unsigned ARCH_REG_ADDR_W = 5,
   parameter int unsigned REG_VAL_W       = 32,
   parameter int unsigned TIMEOUT_CYCLES  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dump_start,
   output logic                     dump_busy,
   output logic                     dump_done,
   output logic                     err_timeout,
   arch_regfile_dump_ctrl_if.master bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   localparam logic [CntW-1:0]            CntLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [ARCH_REG_ADDR_W-1:0] IdxLast = ARCH_REG_ADDR_W'(NUM_ARCH_REGS - 1);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StReq  = 3'd1;
   localparam logic [2:0] StWait = 3'd2;
   localparam logic [2:0] StHold = 3'd3;
   localparam logic [2:0] StDone = 3'd4;

   logic [2:0]                 state_q, state_d;
   logic [ARCH_REG_ADDR_W-1:0] idx_q, idx_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       rd_en_q, rd_en_d;
   logic [ARCH_REG_ADDR_W-1:0] req_addr_q, req_addr_d;
   logic                       out_valid_q, out_valid_d;
   logic [ARCH_REG_ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [REG_VAL_W-1:0]       out_value_q, out_value_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      out_addr_d  = out_addr_q;
      out_value_d = out_value_q;

      unique case (state_q)
         StIdle: begin
            if (dump_start) begin
               state_d = StReq;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         StReq: begin
            state_d = StWait;
            cnt_d   = '0;
         end
         StWait: begin
            // A return on the last allowed WAIT cycle still wins over the abort.
            if (bus.read_valid) begin
               state_d     = StHold;
               out_addr_d  = idx_q;
               out_value_d = bus.read_value;
            end else if (cnt_q == CntLast) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StHold: begin
            if (bus.out_ready) begin
               if (idx_q == IdxLast) begin
                  state_d = StDone;
               end else begin
                  state_d = StReq;
                  idx_d   = idx_q + ARCH_REG_ADDR_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are decoded from the next state so they are flop outputs.
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      rd_en_d     = (state_d == StReq);
      req_addr_d  = rd_en_d ? idx_d : req_addr_q;
      out_valid_d = (state_d == StHold);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         req_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_value_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         req_addr_q  <= req_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_value_q <= out_value_d;
      end
   end

   assign dump_busy             = busy_q;
   assign dump_done             = done_q;
   assign err_timeout           = err_q;
   assign bus.rd_en             = rd_en_q;
   assign bus.read_red_addr_req = req_addr_q;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_addr          = out_addr_q;
   assign bus.out_value         = out_value_q;

endmodule

// File: tb/tb_arch_regfile_dump_ctrl.sv
// Directed bench for arch_regfile_dump_ctrl: a regfile/sink model drives the bus and a
// per-cycle monitor scores the record stream against the expected register contents.
module tb_arch_regfile_dump_ctrl;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int VW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dump_start = 1'b0;
   logic dump_busy, dump_done, err_timeout;

   arch_regfile_dump_ctrl_if #(.ARCH_REG_ADDR_W(AW), .REG_VAL_W(VW)) bus ();

   arch_regfile_dump_ctrl #(
      .NUM_ARCH_REGS  (N),
      .ARCH_REG_ADDR_W(AW),
      .REG_VAL_W      (VW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .err_timeout(err_timeout),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [VW-1:0] mem [N];
   int checks = 0;
   int errors = 0;
   int withhold = -1;
   bit stall_en = 1'b0;
   bit spur_en = 1'b0;
   bit force_rv = 1'b0;
   int rec_cnt = 0, rd_next = 0, done_cnt = 0, exp_recs = 0;
   int done_cyc = -1, first_hs_cyc = -1, last_rd_cyc = -1, t0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(dump_busy), 0);
      chk({tag, "_done"}, 32'(dump_done), 0);
      chk({tag, "_err"}, 32'(err_timeout), 0);
      chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
      chk({tag, "_rd_addr"}, 32'(bus.read_red_addr_req), 0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_out_addr"}, 32'(bus.out_addr), 0);
      chk({tag, "_out_value"}, bus.out_value, 0);
   endtask

   // Regfile with a one-cycle registered read plus a downstream sink.
   initial begin
      logic          pend;
      logic [AW-1:0] paddr;
      int            stall_left;
      int            last_stalled;
      pend = 1'b0;
      paddr = '0;
      stall_left = 0;
      last_stalled = -1;
      bus.read_valid = 1'b0;
      bus.read_value = '0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            pend = 1'b0;
            bus.read_valid = 1'b0;
            stall_left = 0;
            last_stalled = -1;
         end else begin
            bus.read_valid = pend || force_rv || (spur_en && bus.out_valid);
            bus.read_value = pend ? mem[paddr] : 32'hBAD0_0000;
            force_rv = 1'b0;
            pend = bus.rd_en && (int'(bus.read_red_addr_req) != withhold);
            paddr = bus.read_red_addr_req;
            if (stall_en && bus.out_valid && (int'(bus.out_addr) % 3 == 2) &&
                int'(bus.out_addr) != last_stalled) begin
               last_stalled = int'(bus.out_addr);
               stall_left = 5;
            end
            bus.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
         end
      end
   end

   // Per-cycle scoreboard: record k must be (k, mem[k]); read k only after record k-1.
   initial begin
      bit            hold_prev;
      logic [AW-1:0] pa;
      logic [VW-1:0] pv;
      hold_prev = 1'b0;
      pa = '0;
      pv = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            hold_prev = 1'b0;
         end else begin
            if (bus.rd_en) begin
               chk("rd_addr", 32'(bus.read_red_addr_req), rd_next);
               chk("rd_after_handshake", rec_cnt, rd_next);
               chk("rd_while_busy", 32'(dump_busy), 1);
               last_rd_cyc = cyc;
               rd_next++;
            end
            if (!dump_busy) begin
               chk("idle_rd_en", 32'(bus.rd_en), 0);
               chk("idle_out_valid", 32'(bus.out_valid), 0);
            end
            if (bus.out_valid) begin
               if (hold_prev) begin
                  chk("hold_addr_stable", 32'(bus.out_addr), 32'(pa));
                  chk("hold_value_stable", bus.out_value, pv);
               end
               if (bus.out_ready) begin
                  chk("rec_addr", 32'(bus.out_addr), rec_cnt);
                  chk("rec_value", bus.out_value, mem[rec_cnt % N]);
                  chk("rec_in_range", 32'(rec_cnt < exp_recs), 1);
                  if (rec_cnt == 0) first_hs_cyc = cyc;
                  rec_cnt++;
               end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            pa = bus.out_addr;
            pv = bus.out_value;
            if (dump_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic start_dump(input int recs);
      rec_cnt = 0;
      rd_next = 0;
      done_cnt = 0;
      done_cyc = -1;
      first_hs_cyc = -1;
      exp_recs = recs;
      @(posedge clk);
      #1 dump_start = 1'b1;
      @(posedge clk);
      #1 dump_start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_done_seen"}, 32'(done_cnt != 0), 1);
      repeat (5) @(posedge clk);
      #1;
      chk({name, "_done_once"}, done_cnt, 1);
      chk({name, "_busy_after"}, 32'(dump_busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int nstall;
      bit found;
      for (int i = 0; i < N; i++) mem[i] = 32'h1000 + 32'(i);

      // Reset and idle
      #2 reset = 1'b0;
      #1 chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(posedge clk);
      #1 chk_all_zero("idle");

      // Full dump, always ready: done in cycle 97, first record accepted in cycle 3
      start_dump(N);
      chk("full_busy_c1", 32'(dump_busy), 1);
      chk("full_rd_en_c1", 32'(bus.rd_en), 1);
      wait_done("full", 200);
      chk("full_records", rec_cnt, 32);
      chk("full_done_cycle", done_cyc - t0, 96);
      chk("full_first_record_cycle", first_hs_cyc - t0, 2);
      chk("full_err", 32'(err_timeout), 0);

      // Backpressure: 5 stall cycles on every record with addr % 3 == 2
      stall_en = 1'b1;
      start_dump(N);
      wait_done("bp", 400);
      nstall = 0;
      for (int i = 0; i < N; i++) if (i % 3 == 2) nstall++;
      chk("bp_records", rec_cnt, N);
      chk("bp_done_cycle", done_cyc - t0, 3 * N + 5 * nstall);
      chk("bp_done_cycle_lit", done_cyc - t0, 146);
      stall_en = 1'b0;

      // Timeout on reg 7: REQ in cycle 22, 8 WAIT cycles, DONE in cycle 31
      withhold = 7;
      start_dump(7);
      wait_done("to", 200);
      chk("to_records", rec_cnt, 7);
      chk("to_reads", rd_next, 8);
      chk("to_done_cycle", done_cyc - t0, 30);
      chk("to_wait_len", done_cyc - last_rd_cyc, TO + 1);
      chk("to_err", 32'(err_timeout), 1);
      withhold = -1;
      repeat (5) @(posedge clk);
      #1 chk("to_err_sticky", 32'(err_timeout), 1);
      start_dump(N);
      chk("to_err_cleared", 32'(err_timeout), 0);
      wait_done("to_rerun", 200);
      chk("to_rerun_records", rec_cnt, N);
      chk("to_rerun_done_cycle", done_cyc - t0, 96);
      chk("to_rerun_err", 32'(err_timeout), 0);

      // Async reset during HOLD of reg 12
      start_dump(N);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.out_valid && int'(bus.out_addr) == 12) found = 1'b1;
      end
      chk("rst_hold12_found", 32'(found), 1);
      #2 reset = 1'b0;
      #1 chk_all_zero("rst_async");
      repeat (2) @(posedge clk);
      #1;
      rec_cnt = 0;
      rd_next = 0;
      done_cnt = 0;
      exp_recs = 0;
      reset = 1'b1;
      force_rv = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("rst_no_records", rec_cnt, 0);
      chk("rst_no_done", done_cnt, 0);
      chk("rst_no_reads", rd_next, 0);
      chk("rst_idle_busy", 32'(dump_busy), 0);

      // Spurious dump_start while busy and read_valid during every HOLD
      spur_en = 1'b1;
      start_dump(N);
      repeat (10) @(posedge clk);
      #1 dump_start = 1'b1;
      @(posedge clk);
      #1 dump_start = 1'b0;
      wait_done("spur", 200);
      chk("spur_records", rec_cnt, N);
      chk("spur_done_cycle", done_cyc - t0, 96);
      chk("spur_err", 32'(err_timeout), 0);
      spur_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arch_regfile_dump_ctrl.md
Name: arch_regfile_dump_ctrl

Overview:
Master-side read engine for the architectural register file read interface. On a start pulse it walks architectural registers 0..NUM_ARCH_REGS-1. It issues one read at a time over the rd_en / read_red_addr_req request channel and captures read_value when read_valid returns. Each (address, value) pair is streamed out on a valid/ready port. Used for end-of-test architectural state dump and debug snapshot; sits beside the commit path and never writes the regfile.

Parameters:
NUM_ARCH_REGS, 32, number of architectural registers walked per dump
ARCH_REG_ADDR_W, 5, width of architectural register address (>= clog2(NUM_ARCH_REGS))
REG_VAL_W, 32, register value width
TIMEOUT_CYCLES, 8, max cycles in WAIT for read_valid before abort (>= 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
dump_start  in  1  single-cycle request to begin a dump
dump_busy  out  1  high from the cycle after accepted start until DONE exits
dump_done  out  1  one-cycle pulse at end of dump (normal or aborted)
err_timeout  out  1  sticky, set on read timeout, cleared on next accepted dump_start
rd_en  out  1  read request strobe to regfile read interface
read_red_addr_req  out  ARCH_REG_ADDR_W  architectural address of the read
read_value  in  REG_VAL_W  returned register value
read_valid  in  1  return strobe for read_value
out_valid  out  1  dump record valid
out_ready  in  1  downstream accepts record
out_addr  out  ARCH_REG_ADDR_W  address of record
out_value  out  REG_VAL_W  value of record

Behaviour:
- Reset (reset=0, async): state=IDLE; idx=0; timeout cnt=0. All outputs 0: dump_busy, dump_done, err_timeout, rd_en, read_red_addr_req, out_valid, out_addr, out_value.
- Reset asserted mid-dump aborts immediately: no dump_done pulse, no further records. An in-flight read_valid after release is ignored (state is IDLE).
- All outputs are registered. States: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE: when dump_start=1 → REQ; idx=0; err_timeout cleared. dump_start is ignored in every other state.
- REQ (1 cycle): rd_en=1, read_red_addr_req=idx → WAIT; cnt=0. rd_en is high only in REQ, so exactly one outstanding read at a time.
- WAIT: rd_en=0.
  - If read_valid=1: capture out_value<=read_value and out_addr<=idx; out_valid=1 next cycle → HOLD.
  - Else cnt++. When cnt reaches TIMEOUT_CYCLES-1 without read_valid: set err_timeout, out_valid stays 0 → DONE (abort).
  - Nominal regfile return is 1 cycle after rd_en (registered read), i.e. read_valid arrives in the first WAIT cycle.
- HOLD: out_valid=1; out_addr and out_value stable until handshake.
  - On out_valid&out_ready: out_valid deasserts next cycle. If idx==NUM_ARCH_REGS-1 → DONE, else idx++ → REQ.
  - out_ready may be held high indefinitely or toggle; no record is dropped or duplicated.
- DONE (1 cycle): dump_done=1, dump_busy=0 next cycle → IDLE.
- dump_busy=1 in REQ, WAIT, HOLD, DONE.
- read_valid outside WAIT is ignored (no capture, no error).
- idx comparison uses the full ARCH_REG_ADDR_W width; no wrap beyond NUM_ARCH_REGS-1.
- Throughput with out_ready=1: 3 cycles per register (REQ, WAIT, HOLD). A full 32-reg dump is 96 cycles plus 1 DONE cycle.
- Register 0 is read like any other; its value is whatever the regfile returns.

Test Plan:
- Reset then idle: hold dump_start=0 for 20 cycles → all outputs 0; rd_en never asserts.
- Full dump, regfile preloaded reg[i]=0x1000+i, 1-cycle return, out_ready=1 → 32 records in addr order 0..31 with values 0x1000..0x101F; dump_done pulses once at cycle 97 after start; err_timeout=0.
- Backpressure: out_ready low for 5 cycles on every 3rd record → out_addr/out_value stable while out_valid=1 and out_ready=0; still 32 records, no duplicates; rd_en for next reg only after handshake.
- Timeout: regfile model withholds read_valid for reg 7 → records 0..6 only; err_timeout=1 after 8 WAIT cycles; dump_done pulse; a new dump_start clears err_timeout and completes all 32 records.
- Async reset mid-dump: assert reset during HOLD of reg 12 → outputs 0 immediately (not clock-aligned); after release no record and no dump_done until a new dump_start.
- Spurious/overlap: pulse dump_start during busy and read_valid during HOLD → ignored; record sequence and count unchanged.
